// File: rtl/idct8_col_collect.sv
// Collects the skewed outputs of the 8-stage systolic IDCT column into rows,
// saturates each element and queues rows in a small FWFT FIFO.
module idct8_col_collect #(
    parameter int IN_W  = 25,
    parameter int OUT_W = 16,
    parameter int DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic signed [IN_W-1:0]      col_1,
    input  logic signed [IN_W-1:0]      col_2,
    input  logic signed [IN_W-1:0]      col_3,
    input  logic signed [IN_W-1:0]      col_4,
    input  logic signed [IN_W-1:0]      col_5,
    input  logic signed [IN_W-1:0]      col_6,
    input  logic signed [IN_W-1:0]      col_7,
    input  logic signed [IN_W-1:0]      col_8,
    input  logic                        col_valid,
    input  logic                        out_ready,
    output logic [8*OUT_W-1:0]          row_out,
    output logic                        out_valid,
    output logic [$clog2(DEPTH):0]      fifo_count,
    output logic                        sat_pulse,
    output logic                        overflow
);

    localparam int AW = $clog2(DEPTH);

    localparam logic signed [IN_W-1:0] MAXV =
        {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [IN_W-1:0] MINV =
        {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic signed [IN_W-1:0] col_in  [8];
    logic signed [IN_W-1:0] aligned [8];

    assign col_in[0] = col_1;
    assign col_in[1] = col_2;
    assign col_in[2] = col_3;
    assign col_in[3] = col_4;
    assign col_in[4] = col_5;
    assign col_in[5] = col_6;
    assign col_in[6] = col_7;
    assign col_in[7] = col_8;

    // Column k (0-based) is delayed 7-k cycles so all elements line up with col_8.
    for (genvar k = 0; k < 7; k++) begin : g_dl
        localparam int L = 7 - k;
        logic signed [IN_W-1:0] dl_q [L];
        logic signed [IN_W-1:0] dl_d [L];

        always_comb begin
            dl_d[0] = col_in[k];
            for (int i = 1; i < L; i++) begin
                dl_d[i] = dl_q[i-1];
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                for (int i = 0; i < L; i++) begin
                    dl_q[i] <= '0;
                end
            end else begin
                dl_q <= dl_d;
            end
        end

        assign aligned[k] = dl_q[L-1];
    end

    assign aligned[7] = col_in[7];

    logic [6:0] vld_q;
    logic [6:0] vld_d;
    logic       wr;

    assign vld_d = {vld_q[5:0], col_valid};
    assign wr    = vld_q[6];

    logic [8*OUT_W-1:0] row_sat;
    logic               sat_any;

    always_comb begin
        row_sat = '0;
        sat_any = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (aligned[k] > MAXV) begin
                row_sat[k*OUT_W +: OUT_W] = MAXV[OUT_W-1:0];
                sat_any = 1'b1;
            end else if (aligned[k] < MINV) begin
                row_sat[k*OUT_W +: OUT_W] = MINV[OUT_W-1:0];
                sat_any = 1'b1;
            end else begin
                row_sat[k*OUT_W +: OUT_W] = aligned[k][OUT_W-1:0];
            end
        end
    end

    logic [AW:0]        wp_q;
    logic [AW:0]        wp_d;
    logic [AW:0]        rp_q;
    logic [AW:0]        rp_d;
    logic [8*OUT_W-1:0] mem_q [DEPTH];
    logic [8*OUT_W-1:0] mem_d [DEPTH];
    logic               sat_q;
    logic               sat_d;
    logic               ovf_q;
    logic               ovf_d;
    logic               empty;
    logic               full;
    logic               pop;
    logic               push;

    assign empty = (wp_q == rp_q);
    assign full  = (wp_q[AW-1:0] == rp_q[AW-1:0]) && (wp_q[AW] != rp_q[AW]);
    assign pop   = !empty && out_ready;
    // A full FIFO still accepts a row when the head leaves on the same edge.
    assign push  = wr && (!full || pop);

    always_comb begin
        wp_d  = wp_q + {{AW{1'b0}}, push};
        rp_d  = rp_q + {{AW{1'b0}}, pop};
        mem_d = mem_q;
        if (push) begin
            mem_d[wp_q[AW-1:0]] = row_sat;
        end
        sat_d = wr && sat_any;
        ovf_d = ovf_q || (wr && full && !pop);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q <= '0;
            wp_q  <= '0;
            rp_q  <= '0;
            sat_q <= 1'b0;
            ovf_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            sat_q <= sat_d;
            ovf_q <= ovf_d;
            mem_q <= mem_d;
        end
    end

    assign row_out    = mem_q[rp_q[AW-1:0]];
    assign out_valid  = !empty;
    assign fifo_count = wp_q - rp_q;
    assign sat_pulse  = sat_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_idct8_col_collect.sv
// Bench for idct8_col_collect: skewed row driver, queue-based FIFO model,
// vector table and directed corner-case sequences.
module tb_idct8_col_collect;

    localparam int IN_W  = 25;
    localparam int OUT_W = 16;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic             v;
        logic             sat;
        logic [7:0][31:0] in_v;
        logic [7:0][15:0] ex_v;
    } rec_t;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic                   col_valid = 1'b0;
    logic                   out_ready = 1'b0;
    logic signed [IN_W-1:0] col [8];
    logic [8*OUT_W-1:0]     row_out;
    logic                   out_valid;
    logic [2:0]             fifo_count;
    logic                   sat_pulse;
    logic                   overflow;

    int checks = 0;
    int errors = 0;

    rec_t         hist [8];
    logic [127:0] q [$];
    logic         mdl_ovf = 1'b0;
    logic         mdl_sat = 1'b0;
    logic         m_pop;
    logic         m_wr;
    rec_t         idle = '0;
    rec_t         vec [4];

    int ai [4][8] = '{
        '{100, 200, 300, 400, 500, 600, 700, 800},
        '{40000, -40000, 32767, -32768, 0, 0, 0, 0},
        '{32767, -32768, 5, -5, 1000, -1000, 0, 123},
        '{32768, -32769, 16777215, -16777216, -1, 1, 0, 0}
    };
    int ae [4][8] = '{
        '{100, 200, 300, 400, 500, 600, 700, 800},
        '{32767, -32768, 32767, -32768, 0, 0, 0, 0},
        '{32767, -32768, 5, -5, 1000, -1000, 0, 123},
        '{32767, -32768, 32767, -32768, -1, 1, 0, 0}
    };
    bit as [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

    always #5 clk = ~clk;

    idct8_col_collect #(
        .IN_W(IN_W),
        .OUT_W(OUT_W),
        .DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .col_1(col[0]),
        .col_2(col[1]),
        .col_3(col[2]),
        .col_4(col[3]),
        .col_5(col[4]),
        .col_6(col[5]),
        .col_7(col[6]),
        .col_8(col[7]),
        .col_valid(col_valid),
        .out_ready(out_ready),
        .row_out(row_out),
        .out_valid(out_valid),
        .fifo_count(fifo_count),
        .sat_pulse(sat_pulse),
        .overflow(overflow)
    );

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic rec_t mk(input int r);
        rec_t x;
        x = '0;
        x.v = 1'b1;
        for (int k = 0; k < 8; k++) begin
            x.in_v[k] = 10 * r + k + 1;
            x.ex_v[k] = 16'(10 * r + k + 1);
        end
        return x;
    endfunction

    task automatic clr_hist();
        for (int i = 0; i < 8; i++) begin
            hist[i] = '0;
        end
    endtask

    // Drive one cycle: col_k carries element k of the row issued k cycles ago.
    task automatic step(input rec_t r);
        for (int i = 7; i > 0; i--) begin
            hist[i] = hist[i-1];
        end
        hist[0] = r;
        col_valid = r.v;
        for (int k = 0; k < 8; k++) begin
            col[k] = hist[k].v ? hist[k].in_v[k][IN_W-1:0] : '1;
        end
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: compare outputs, then advance the FIFO model across the edge.
    always @(negedge clk) begin
        if (reset) begin
            q.delete();
            mdl_ovf = 1'b0;
            mdl_sat = 1'b0;
        end else begin
            chk("out_valid", 128'(out_valid), 128'(q.size() != 0));
            chk("fifo_count", 128'(fifo_count), 128'(q.size()));
            chk("overflow", 128'(overflow), 128'(mdl_ovf));
            chk("sat_pulse", 128'(sat_pulse), 128'(mdl_sat));
            if (q.size() != 0) begin
                chk("row_out", row_out, q[0]);
            end
            m_pop = (q.size() != 0) && out_ready;
            m_wr  = hist[7].v;
            if (m_pop) begin
                void'(q.pop_front());
            end
            if (m_wr) begin
                if (q.size() < DEPTH) begin
                    q.push_back(hist[7].ex_v);
                end else begin
                    mdl_ovf = 1'b1;
                end
            end
            mdl_sat = m_wr && hist[7].sat;
        end
    end

    initial begin
        for (int i = 0; i < 4; i++) begin
            vec[i] = '0;
            vec[i].v = 1'b1;
            vec[i].sat = as[i];
            for (int k = 0; k < 8; k++) begin
                vec[i].in_v[k] = ai[i][k];
                vec[i].ex_v[k] = 16'(ae[i][k]);
            end
        end
        for (int i = 0; i < 8; i++) begin
            col[i] = '1;
        end
        clr_hist();

        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 128'(out_valid), 128'(0));
        chk("rst_count", 128'(fifo_count), 128'(0));
        chk("rst_sat", 128'(sat_pulse), 128'(0));
        chk("rst_ovf", 128'(overflow), 128'(0));
        chk("rst_row", row_out, 128'(0));
        reset = 1'b0;

        // Single row: latency 8, held until popped.
        out_ready = 1'b0;
        step(vec[0]);
        repeat (6) step(idle);
        chk("lat_early", 128'(out_valid), 128'(0));
        step(idle);
        chk("lat_valid", 128'(out_valid), 128'(1));
        chk("lat_row", row_out, 128'(vec[0].ex_v));
        chk("lat_count", 128'(fifo_count), 128'(1));
        out_ready = 1'b1;
        step(idle);
        chk("pop_empty", 128'(out_valid), 128'(0));
        repeat (3) step(idle);

        for (int i = 1; i < 4; i++) begin
            step(vec[i]);
            repeat (7) step(idle);
            chk("vec_row", row_out, 128'(vec[i].ex_v));
            chk("vec_sat", 128'(sat_pulse), 128'(vec[i].sat));
            repeat (4) step(idle);
        end

        // Back-to-back rows, consumer always ready.
        for (int r = 0; r < 8; r++) begin
            step(mk(r));
        end
        repeat (12) step(idle);

        // Overflow: five rows into a four-deep FIFO with no consumer.
        out_ready = 1'b0;
        for (int r = 0; r < 5; r++) begin
            step(mk(20 + r));
        end
        repeat (10) step(idle);
        chk("ovf_count", 128'(fifo_count), 128'(4));
        chk("ovf_flag", 128'(overflow), 128'(1));
        out_ready = 1'b1;
        repeat (8) step(idle);
        chk("ovf_sticky", 128'(overflow), 128'(1));

        // Asynchronous reset with two rows buffered and one in flight.
        out_ready = 1'b0;
        step(mk(40));
        step(mk(41));
        repeat (10) step(idle);
        step(mk(42));
        repeat (2) step(idle);
        #2;
        reset = 1'b1;
        clr_hist();
        #1;
        chk("arst_valid", 128'(out_valid), 128'(0));
        chk("arst_count", 128'(fifo_count), 128'(0));
        chk("arst_ovf", 128'(overflow), 128'(0));
        chk("arst_sat", 128'(sat_pulse), 128'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        out_ready = 1'b1;
        repeat (10) step(idle);
        step(mk(50));
        repeat (6) step(idle);
        chk("fresh_early", 128'(out_valid), 128'(0));
        step(idle);
        chk("fresh_valid", 128'(out_valid), 128'(1));
        chk("fresh_row", row_out, 128'(mk(50).ex_v));
        repeat (3) step(idle);

        // Full FIFO with a pop on the same edge the fifth row completes.
        out_ready = 1'b0;
        for (int r = 0; r < 5; r++) begin
            step(mk(60 + r));
        end
        repeat (6) step(idle);
        chk("full_before", 128'(fifo_count), 128'(4));
        out_ready = 1'b1;
        step(idle);
        out_ready = 1'b0;
        chk("full_count", 128'(fifo_count), 128'(4));
        chk("full_ovf", 128'(overflow), 128'(0));
        chk("full_head", row_out, 128'(mk(61).ex_v));
        out_ready = 1'b1;
        repeat (10) step(idle);
        chk("final_empty", 128'(out_valid), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
